pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 4: sequential PC increment in bytes.
REQ-003 SHALL provide: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide: run  input  1  level; leaves IDLE and starts fetching.
REQ-006 SHALL provide: imem_req  output  1  fetch request, held until imem_ready.
REQ-007 SHALL provide: imem_addr  output  32  fetch address, equals pc.
REQ-008 SHALL provide: imem_ready  input  1  instruction word available this cycle.
REQ-009 SHALL provide: instr_valid  output  1  one-cycle pulse, instruction handed to datapath.
REQ-010 SHALL provide: exec_done  input  1  datapath finished current instruction.
REQ-011 SHALL provide: BranchControl  input  1  current instruction is a conditional branch.
REQ-012 SHALL provide: FlagControl  input  4  branch condition code.
REQ-013 SHALL provide: jump_addr  input  32  branch target.
REQ-014 SHALL provide: flag_we, zero_flag, sign_flag, carry_flag, overflow_flag  input  1 each  ALU flag write enable and flags.
REQ-015 SHALL provide: pc  output  32  current program counter; flags  output  4  {Z,S,C,V} register.

Function
REQ-016 SHALL implement FSM IDLE, FETCH, EXEC; IDLE->FETCH when run=1; FETCH->EXEC on imem_ready; EXEC->FETCH on exec_done, or ->IDLE on exec_done when run=0.
REQ-017 SHALL assert imem_req only in FETCH; imem_ready outside FETCH is ignored.
REQ-018 SHALL assert instr_valid exactly in the first cycle of EXEC.
REQ-019 SHALL accept exec_done in the same cycle as instr_valid (minimum 2 cycles per instruction); exec_done outside EXEC is ignored.
REQ-020 SHALL, on exec_done in EXEC, load pc with {jump_addr[31:2],2'b00} if BranchControl=1 and the condition holds, else pc+PC_STEP modulo 2^32 (32'hFFFF_FFFC+4 -> 0).
REQ-021 SHALL evaluate the condition against the flags register value before that cycle's update (flags from the previous flag-writing instruction).
REQ-022 SHALL, on exec_done with flag_we=1, load flags with {zero,sign,carry,overflow}_flag; flag_we without exec_done is ignored.
REQ-023 SHALL decode FlagControl: 0000 always, 0001 Z, 0010 !Z, 0011 S, 0100 !S, 0101 C, 0110 !C, 0111 V, 1000 !V, 1001 S^V (LT), 1010 !(S^V) (GE), 1011 Z|(S^V) (LE), 1100 !Z&!(S^V) (GT), 1101-1111 never.
REQ-024 SHALL keep pc and flags unchanged in IDLE and FETCH.
REQ-025 SHALL complete an instruction in EXEC even if run falls mid-instruction, then stop in IDLE.

Reset
REQ-026 SHALL, while reset=1, force state IDLE, pc=imem_addr=RESET_VECTOR, flags=4'b0000, imem_req=0, instr_valid=0, asynchronously, including mid-fetch or mid-execute.
REQ-027 SHALL resume from IDLE on the first rising edge after reset deasserts with run=1.

Structure
REQ-028 SHALL place FlagControl condition-code constants, state encoding and the 4-bit flag-field layout in shared package cpu_pkg.
REQ-029 SHALL implement condition decode (REQ-023) as combinational sub-module branch_cond (inputs flags, FlagControl; output taken).

Verification
REQ-030 Reset, run=1, imem_ready=1 every cycle, exec_done=1, BranchControl=0 -> imem_addr 0,4,8,12 on successive fetches; instr_valid pulses every 2nd cycle.
REQ-031 Flags loaded {Z=0,S=1,C=0,V=1}, then branch FlagControl=4'b1100, jump_addr=40 at pc=0 -> pc=40 (GT taken).
REQ-032 Same flags, FlagControl=4'b1001, jump_addr=40 at pc=8 -> pc=12 (LT not taken); FlagControl=4'b1111 -> never taken.
REQ-033 Branch with flag_we=1 writing Z=1 and FlagControl=0001, prior Z=0 -> not taken; next such branch -> taken; jump_addr=43 -> pc=40.
REQ-034 pc=32'hFFFF_FFFC, non-branch exec_done -> pc=0; imem_ready held low 5 cycles -> imem_req held, no instr_valid.
REQ-035 Reset asserted mid-EXEC at pc=40 -> immediate pc=0, flags=0, imem_req=0; run=0 during EXEC -> IDLE after exec_done.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter sequencer.
//   state_t      : sequencer FSM encoding (IDLE, FETCH, EXEC)
//   COND_*       : FlagControl condition codes seen by branch_cond
//   FLAG_*       : bit positions inside the 4-bit {Z,S,C,V} flag register
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } state_t;

  typedef logic [3:0] flags_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_AL  = 4'b0000;
  localparam logic [3:0] COND_EQ  = 4'b0001;
  localparam logic [3:0] COND_NE  = 4'b0010;
  localparam logic [3:0] COND_MI  = 4'b0011;
  localparam logic [3:0] COND_PL  = 4'b0100;
  localparam logic [3:0] COND_CS  = 4'b0101;
  localparam logic [3:0] COND_CC  = 4'b0110;
  localparam logic [3:0] COND_VS  = 4'b0111;
  localparam logic [3:0] COND_VC  = 4'b1000;
  localparam logic [3:0] COND_LT  = 4'b1001;
  localparam logic [3:0] COND_GE  = 4'b1010;
  localparam logic [3:0] COND_LE  = 4'b1011;
  localparam logic [3:0] COND_GT  = 4'b1100;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch bus plus datapath handshake between the sequencer and the core.
//   imem_req/imem_addr/imem_ready : instruction fetch handshake
//   instr_valid/exec_done         : instruction issue / completion
//   BranchControl/FlagControl/jump_addr : branch request for current instr
//   flag_we + {zero,sign,carry,overflow}_flag : ALU flag update
// master = sequencer side, slave = memory/datapath side.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        instr_valid;
  logic        exec_done;
  logic        BranchControl;
  logic [3:0]  FlagControl;
  logic [31:0] jump_addr;
  logic        flag_we;
  logic        zero_flag;
  logic        sign_flag;
  logic        carry_flag;
  logic        overflow_flag;

  modport master (
    output imem_req, imem_addr, instr_valid,
    input  imem_ready, exec_done, BranchControl, FlagControl, jump_addr,
           flag_we, zero_flag, sign_flag, carry_flag, overflow_flag
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid,
    output imem_ready, exec_done, BranchControl, FlagControl, jump_addr,
           flag_we, zero_flag, sign_flag, carry_flag, overflow_flag
  );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch-condition decode.
//   flags       : {Z,S,C,V} register value
//   FlagControl : condition code
//   taken       : 1 when the condition holds
module branch_cond
  import cpu_pkg::*;
(
  input  flags_t     flags,
  input  logic [3:0] FlagControl,
  output logic       taken
);
  logic z, s, c, v, lt;

  assign z  = flags[FLAG_Z];
  assign s  = flags[FLAG_S];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign lt = s ^ v;

  always_comb begin
    taken = 1'b0;
    case (FlagControl)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_MI: taken = s;
      COND_PL: taken = ~s;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_LT: taken = lt;
      COND_GE: taken = ~lt;
      COND_LE: taken = z | lt;
      COND_GT: taken = ~z & ~lt;
      default: taken = 1'b0;   // remaining codes never branch
    endcase
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> EXEC loop that fetches one
// instruction at pc, issues it, and on completion steps or branches.
//   clk, reset : clock and asynchronous active-high reset
//   run        : level enable; sequencer stops in IDLE after the current
//                instruction once it drops
//   bus        : fetch / execute handshake (pc_sequencer_if.master)
//   pc         : current program counter
//   flags      : {Z,S,C,V} flag register
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  pc_sequencer_if.master        bus,
  output logic [31:0]           pc,
  output flags_t                flags
);
  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state, state_nxt;
  logic        first_exec;
  logic [31:0] pc_nxt;
  logic [31:0] target;
  flags_t      flags_nxt;
  logic        taken;

  // Condition is judged on the registered flags, i.e. before this
  // instruction's own flag write lands.
  branch_cond u_branch_cond (
    .flags       (flags),
    .FlagControl (bus.FlagControl),
    .taken       (taken)
  );

  assign target = bus.jump_addr & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      first_exec <= 1'b0;
      pc         <= RESET_VECTOR;
      flags      <= 4'b0000;
    end else begin
      state      <= state_nxt;
      // Marks the first EXEC cycle; exec_done may arrive in that same cycle.
      first_exec <= (state == ST_FETCH) && bus.imem_ready;
      pc         <= pc_nxt;
      flags      <= flags_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    flags_nxt = flags;
    case (state)
      ST_IDLE:  if (run) state_nxt = ST_FETCH;
      ST_FETCH: if (bus.imem_ready) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (bus.exec_done) begin
          state_nxt = run ? ST_FETCH : ST_IDLE;
          pc_nxt    = (bus.BranchControl && taken) ? target : pc + STEP;
          if (bus.flag_we)
            flags_nxt = {bus.zero_flag, bus.sign_flag,
                         bus.carry_flag, bus.overflow_flag};
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign bus.imem_req    = (state == ST_FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = first_exec;
endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: vector table, directed corner sequences and
// random stimulus against an instruction-level reference model.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [31:0] pc;
  logic [3:0]  flags;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .PC_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .bus   (bus),
    .pc    (pc),
    .flags (flags)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase of the current instruction, pc, flags, issue pulse
  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_EXEC  = 2;
  int          m_phase;
  logic [31:0] m_pc;
  logic [3:0]  m_flags;
  bit          m_iv;

  typedef struct {
    bit          rf;
    bit          run;
    bit          rdy;
    bit          dn;
    bit          br;
    logic [3:0]  fc;
    logic [31:0] ja;
    bit          fwe;
    logic [3:0]  fl;
    logic [31:0] e_pc;
    logic [3:0]  e_fl;
    bit          e_req;
    bit          e_iv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rf, bit r, bit rdy, bit dn, bit br,
                              logic [3:0] fc, logic [31:0] ja, bit fwe,
                              logic [3:0] fl, logic [31:0] e_pc,
                              logic [3:0] e_fl, bit e_req, bit e_iv);
    vec_t v;
    v.rf = rf; v.run = r; v.rdy = rdy; v.dn = dn; v.br = br; v.fc = fc;
    v.ja = ja; v.fwe = fwe; v.fl = fl; v.e_pc = e_pc; v.e_fl = e_fl;
    v.e_req = e_req; v.e_iv = e_iv;
    return v;
  endfunction

  // {Z,S,C,V}: evaluate every condition, pick the requested one.
  function automatic bit cond_holds(logic [3:0] fc, logic [3:0] f);
    bit res[16];
    bit z, s, c, v;
    z = f[3]; s = f[2]; c = f[1]; v = f[0];
    foreach (res[i]) res[i] = 1'b0;
    res[0]  = 1'b1;
    res[1]  = z;
    res[2]  = !z;
    res[3]  = s;
    res[4]  = !s;
    res[5]  = c;
    res[6]  = !c;
    res[7]  = v;
    res[8]  = !v;
    res[9]  = (s != v);
    res[10] = (s == v);
    res[11] = z || (s != v);
    res[12] = !z && (s == v);
    return res[fc];
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic set_in(bit r, bit rdy, bit dn, bit br, logic [3:0] fc,
                        logic [31:0] ja, bit fwe, logic [3:0] fl);
    run               = r;
    bus.imem_ready    = rdy;
    bus.exec_done     = dn;
    bus.BranchControl = br;
    bus.FlagControl   = fc;
    bus.jump_addr     = ja;
    bus.flag_we       = fwe;
    bus.zero_flag     = fl[3];
    bus.sign_flag     = fl[2];
    bus.carry_flag    = fl[1];
    bus.overflow_flag = fl[0];
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_pc    = 32'h0;
    m_flags = 4'h0;
    m_iv    = 1'b0;
  endtask

  task automatic model_step();
    m_iv = 1'b0;
    if (m_phase == PH_IDLE) begin
      if (run) m_phase = PH_FETCH;
    end else if (m_phase == PH_FETCH) begin
      if (bus.imem_ready) begin
        m_phase = PH_EXEC;
        m_iv    = 1'b1;
      end
    end else if (bus.exec_done) begin
      if (bus.BranchControl && cond_holds(bus.FlagControl, m_flags))
        m_pc = {bus.jump_addr[31:2], 2'b00};
      else
        m_pc = m_pc + 32'd4;
      if (bus.flag_we)
        m_flags = {bus.zero_flag, bus.sign_flag, bus.carry_flag, bus.overflow_flag};
      m_phase = run ? PH_FETCH : PH_IDLE;
    end
  endtask

  task automatic compare_model(string tag);
    chk({tag, "_pc"},    pc, m_pc);
    chk({tag, "_addr"},  bus.imem_addr, m_pc);
    chk({tag, "_flags"}, 32'(flags), 32'(m_flags));
    chk({tag, "_req"},   32'(bus.imem_req), 32'(m_phase == PH_FETCH));
    chk({tag, "_iv"},    32'(bus.instr_valid), 32'(m_iv));
  endtask

  // Advance one clock; inputs are already stable, outputs read at negedge.
  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model(tag);
  endtask

  // Called at a negedge; leaves reset released at a later negedge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_pc",    pc, 32'h0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_req",   32'(bus.imem_req), 32'h0);
    chk("rst_iv",    32'(bus.instr_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0);
    model_reset();

    // Straight-line fetch, then flag/branch scenarios
    vecs.push_back(mk(1,1,1,1,0,4'h0,32'd0,0,4'h0, 32'd0, 4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0,4'h0,32'd0,0,4'h0, 32'd0, 4'h0,0,1));
    vecs.push_back(mk(0,1,1,1,0,4'h0,32'd0,0,4'h0, 32'd4, 4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0,4'h0,32'd0,0,4'h0, 32'd4, 4'h0,0,1));
    vecs.push_back(mk(0,1,1,1,0,4'h0,32'd0,0,4'h0, 32'd8, 4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0,4'h0,32'd0,0,4'h0, 32'd8, 4'h0,0,1));
    vecs.push_back(mk(0,1,1,1,0,4'h0,32'd0,0,4'h0, 32'd12,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0,4'h0,32'd0,0,4'h0, 32'd12,4'h0,0,1));
    vecs.push_back(mk(1,1,1,0,0,4'h0,32'd0,0,4'h0, 32'd0, 4'h0,1,0));
    vecs.push_back(mk(0,1,1,0,0,4'h0,32'd0,0,4'h0, 32'd0, 4'h0,0,1));
    vecs.push_back(mk(0,1,1,1,0,4'h0,32'd0,1,4'h5, 32'd4, 4'h5,1,0));
    vecs.push_back(mk(0,1,1,1,0,4'h0,32'd0,1,4'hF, 32'd4, 4'h5,0,1));
    vecs.push_back(mk(0,1,0,1,1,4'h0,32'd0,0,4'h0, 32'd0, 4'h5,1,0));
    vecs.push_back(mk(0,1,1,0,0,4'h0,32'd0,0,4'h0, 32'd0, 4'h5,0,1));
    vecs.push_back(mk(0,1,0,1,1,4'hC,32'd40,0,4'h0,32'd40,4'h5,1,0));
    vecs.push_back(mk(0,1,1,0,0,4'h0,32'd0,0,4'h0, 32'd40,4'h5,0,1));
    vecs.push_back(mk(0,1,0,1,1,4'h0,32'd8,0,4'h0, 32'd8, 4'h5,1,0));
    vecs.push_back(mk(0,1,1,0,0,4'h0,32'd0,0,4'h0, 32'd8, 4'h5,0,1));
    vecs.push_back(mk(0,1,0,1,1,4'h9,32'd40,0,4'h0,32'd12,4'h5,1,0));
    vecs.push_back(mk(0,1,1,0,0,4'h0,32'd0,0,4'h0, 32'd12,4'h5,0,1));
    vecs.push_back(mk(0,1,0,1,1,4'hF,32'd40,0,4'h0,32'd16,4'h5,1,0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rf) do_reset();
      set_in(vecs[i].run, vecs[i].rdy, vecs[i].dn, vecs[i].br, vecs[i].fc,
             vecs[i].ja, vecs[i].fwe, vecs[i].fl);
      tick($sformatf("vec%0d_model", i));
      chk($sformatf("vec%0d_pc", i),    pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_addr", i),  bus.imem_addr, vecs[i].e_pc);
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].e_fl));
      chk($sformatf("vec%0d_req", i),   32'(bus.imem_req), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d_iv", i),    32'(bus.instr_valid), 32'(vecs[i].e_iv));
    end

    // Branch that writes Z itself: first uses old Z=0, second sees Z=1
    set_in(1, 1, 0, 0, 4'h0, 32'd0, 0, 4'h0);  tick("z1_fetch");
    set_in(1, 0, 1, 1, 4'h1, 32'd43, 1, 4'h8); tick("z1_exec");
    chk("zbr_not_taken_pc", pc, 32'd20);
    chk("zbr_flags", 32'(flags), 32'h8);
    set_in(1, 1, 0, 0, 4'h0, 32'd0, 0, 4'h0);  tick("z2_fetch");
    set_in(1, 0, 1, 1, 4'h1, 32'd43, 1, 4'h8); tick("z2_exec");
    chk("zbr_taken_pc", pc, 32'd40);

    // pc wrap at the top of the address space
    set_in(1, 1, 0, 0, 4'h0, 32'd0, 0, 4'h0);         tick("w_fetch");
    set_in(1, 0, 1, 1, 4'h0, 32'hFFFF_FFFC, 0, 4'h0); tick("w_br");
    chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
    set_in(1, 1, 0, 0, 4'h0, 32'd0, 0, 4'h0);         tick("w_fetch2");
    set_in(1, 0, 1, 0, 4'h0, 32'd0, 0, 4'h0);         tick("w_step");
    chk("wrap_zero_pc", pc, 32'h0);

    // Memory stall: request held, nothing issued
    for (int k = 0; k < 5; k++) begin
      set_in(1, 0, 1, 0, 4'h0, 32'd0, 1, 4'hF);
      tick("stall");
      chk($sformatf("stall%0d_req", k), 32'(bus.imem_req), 32'h1);
      chk($sformatf("stall%0d_iv", k), 32'(bus.instr_valid), 32'h0);
    end
    set_in(1, 1, 0, 0, 4'h0, 32'd0, 0, 4'h0); tick("stall_end");
    chk("stall_end_iv", 32'(bus.instr_valid), 32'h1);

    // Reach EXEC at pc=40, then reset asynchronously mid-instruction
    set_in(1, 0, 1, 1, 4'h0, 32'd40, 0, 4'h0); tick("r_br");
    set_in(1, 1, 0, 0, 4'h0, 32'd0, 0, 4'h0);  tick("r_fetch");
    chk("pre_reset_pc", pc, 32'd40);
    set_in(1, 0, 0, 0, 4'h0, 32'd0, 0, 4'h0);
    do_reset();
    tick("resume");
    chk("resume_req", 32'(bus.imem_req), 32'h1);

    // run drops mid-instruction: finish it, then idle
    set_in(1, 1, 0, 0, 4'h0, 32'd0, 0, 4'h0); tick("stop_fetch");
    set_in(0, 0, 0, 0, 4'h0, 32'd0, 0, 4'h0); tick("stop_wait");
    chk("stop_wait_req", 32'(bus.imem_req), 32'h0);
    set_in(0, 1, 1, 0, 4'h0, 32'd0, 0, 4'h0); tick("stop_done");
    chk("stop_done_pc", pc, 32'd4);
    tick("stop_idle");
    chk("stop_idle_req", 32'(bus.imem_req), 32'h0);
    chk("stop_idle_pc", pc, 32'd4);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ja;
      ja = $urandom;
      if ($urandom_range(0, 15) == 0) ja = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      set_in($urandom_range(0, 15) != 0, 1'($urandom), $urandom_range(0, 2) != 0,
             1'($urandom), 4'($urandom), ja, 1'($urandom), 4'($urandom));
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
